keypad_hex_scanner: RTL and testbench

- Input-side counterpart to the multiplexed 7-segment hex display driver: scans a 4x4 hex keypad matrix, debounces it and produces hex key codes.
- Drives one column low at a time from a prescaled tick, samples the row lines and qualifies a single pressed key over several full scans.
- Shifts each new key nibble into an 8-bit value that feeds the display's 8-bit n input directly.

---
 rtl/keypad_pkg.sv | 63 ++++++
 rtl/keypad_debounce_fsm.sv | 156 +++++++++++++++
 rtl/keypad_hex_scanner.sv | 130 +++++++++++++
 tb/tb_keypad_hex_scanner.sv | 258 +++++++++++++++++++++++++
 4 files changed

// File: rtl/keypad_pkg.sv
// -----------------------------------------------------------------------------
// keypad_pkg
//
// Shared types and constants for the 4x4 hex keypad scanner.
//   state_t        : debounce FSM states (IDLE, PRESS_DB, HELD, REL_DB)
//   scan_result_t  : classification of one full keypad scan (NONE, SINGLE, MULTI)
//   scan_class_t   : scan classification plus the hex code of a SINGLE key
//   CODE_MAP       : hex code for keypad position (row r, column c) at index r*4+c
//   classify_scan  : turns a 16-bit "key is low" mask into a scan_class_t
// -----------------------------------------------------------------------------
package keypad_pkg;

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        PRESS_DB = 2'd1,
        HELD     = 2'd2,
        REL_DB   = 2'd3
    } state_t;

    typedef enum logic [1:0] {
        NONE   = 2'd0,
        SINGLE = 2'd1,
        MULTI  = 2'd2
    } scan_result_t;

    typedef struct packed {
        scan_result_t result;
        logic [3:0]   code;
    } scan_class_t;

    // Packed MSB-first, so the literal reads bottom row first:
    //   r3: E 0 F D   r2: 7 8 9 C   r1: 4 5 6 B   r0: 1 2 3 A
    // Index r*4+c selects the code for row r, column c.
    localparam logic [15:0][3:0] CODE_MAP = {
        4'hD, 4'hF, 4'h0, 4'hE,
        4'hC, 4'h9, 4'h8, 4'h7,
        4'hB, 4'h6, 4'h5, 4'h4,
        4'hA, 4'h3, 4'h2, 4'h1
    };

    // low_mask[r*4+c] is 1 when row r read low while column c was driven.
    // The code field is only meaningful when the result is SINGLE.
    function automatic scan_class_t classify_scan(input logic [15:0] low_mask);
        scan_class_t cls;
        int unsigned hits;
        cls.result = NONE;
        cls.code   = 4'h0;
        hits       = 0;
        for (int i = 0; i < 16; i++) begin
            if (low_mask[i]) begin
                hits++;
                cls.code = CODE_MAP[i];
            end
        end
        if (hits == 1) begin
            cls.result = SINGLE;
        end else if (hits > 1) begin
            cls.result = MULTI;
        end
        return cls;
    endfunction

endpackage

// File: rtl/keypad_debounce_fsm.sv
// -----------------------------------------------------------------------------
// keypad_debounce_fsm
//
// Qualifies keypad presses and releases over consecutive full-scan results and
// keeps the two most recent accepted key codes for the hex display.
//
// Ports:
//   clk         in   system clock
//   reset       in   synchronous active-high reset
//   scan_done   in   one-clk strobe: scan_result/scan_code describe a full scan
//   scan_result in   NONE / SINGLE / MULTI for the completed scan
//   scan_code   in   hex code of the key when scan_result is SINGLE
//   key_code    out  hex code of the last accepted key
//   key_valid   out  one-clk pulse, the cycle after the accepting scan strobe
//   key_down    out  high while an accepted key is held (HELD or REL_DB)
//   value       out  {previous key_code, newest key_code}
//
// Parameters:
//   DEBOUNCE    consecutive identical scans required to accept press/release
// -----------------------------------------------------------------------------
module keypad_debounce_fsm
    import keypad_pkg::*;
#(
    parameter int DEBOUNCE = 4
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         scan_done,
    input  scan_result_t scan_result,
    input  logic [3:0]   scan_code,
    output logic [3:0]   key_code,
    output logic         key_valid,
    output logic         key_down,
    output logic [7:0]   value
);

    localparam int            CW      = $clog2(DEBOUNCE + 1);
    localparam logic [CW-1:0] DB_MAX  = CW'(DEBOUNCE);
    localparam logic [CW-1:0] CNT_ONE = CW'(1);

    state_t        state_reg, state_next;
    logic [CW-1:0] count_reg, count_next, count_inc;
    logic [3:0]    cand_reg, cand_next;
    logic [3:0]    key_code_reg;
    logic [7:0]    value_reg;
    logic          key_valid_reg;
    logic          accept;

    // Saturating increment: the count never exceeds DEBOUNCE.
    assign count_inc = (count_reg >= DB_MAX) ? DB_MAX : count_reg + CNT_ONE;

    // State and datapath registers.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_reg     <= IDLE;
            count_reg     <= '0;
            cand_reg      <= 4'h0;
            key_code_reg  <= 4'h0;
            value_reg     <= 8'h00;
            key_valid_reg <= 1'b0;
        end else begin
            state_reg     <= state_next;
            count_reg     <= count_next;
            cand_reg      <= cand_next;
            key_valid_reg <= accept;
            if (accept) begin
                key_code_reg <= cand_next;
                value_reg    <= {value_reg[3:0], cand_next};
            end
        end
    end

    // Next-state logic. Only a scan strobe can move the FSM. The count is
    // compared after it has been updated, so DEBOUNCE=1 accepts or releases
    // on the very first qualifying scan without lingering in a DB state.
    always_comb begin
        state_next = state_reg;
        count_next = count_reg;
        cand_next  = cand_reg;
        accept     = 1'b0;
        if (scan_done) begin
            unique case (state_reg)
                IDLE: begin
                    if (scan_result == SINGLE) begin
                        cand_next  = scan_code;
                        count_next = CNT_ONE;
                        if (CNT_ONE >= DB_MAX) begin
                            state_next = HELD;
                            count_next = '0;
                            accept     = 1'b1;
                        end else begin
                            state_next = PRESS_DB;
                        end
                    end
                end
                PRESS_DB: begin
                    if (scan_result == SINGLE) begin
                        if (scan_code == cand_reg) begin
                            count_next = count_inc;
                        end else begin
                            // A different single key restarts qualification.
                            cand_next  = scan_code;
                            count_next = CNT_ONE;
                        end
                        if (count_next >= DB_MAX) begin
                            state_next = HELD;
                            count_next = '0;
                            accept     = 1'b1;
                        end
                    end else begin
                        state_next = IDLE;
                        count_next = '0;
                    end
                end
                HELD: begin
                    // Rollover to another key (SINGLE or MULTI) is ignored
                    // until the pad goes fully quiet.
                    if (scan_result == NONE) begin
                        count_next = CNT_ONE;
                        if (CNT_ONE >= DB_MAX) begin
                            state_next = IDLE;
                            count_next = '0;
                        end else begin
                            state_next = REL_DB;
                        end
                    end
                end
                REL_DB: begin
                    if (scan_result == NONE) begin
                        count_next = count_inc;
                        if (count_next >= DB_MAX) begin
                            state_next = IDLE;
                            count_next = '0;
                        end
                    end else begin
                        state_next = HELD;
                        count_next = '0;
                    end
                end
                default: begin
                    state_next = IDLE;
                    count_next = '0;
                end
            endcase
        end
    end

    // Outputs. key_down is a pure function of state; the rest are registers.
    always_comb begin
        key_down  = (state_reg == HELD) || (state_reg == REL_DB);
        key_valid = key_valid_reg;
        key_code  = key_code_reg;
        value     = value_reg;
    end

endmodule

// File: rtl/keypad_hex_scanner.sv
// -----------------------------------------------------------------------------
// keypad_hex_scanner
//
// Scans a 4x4 hex keypad matrix one column at a time, synchronizes and records
// the row lines, classifies every full scan and hands it to the debounce FSM.
// The 8-bit value output plugs straight into the 7-segment hex display driver.
//
// Ports:
//   clk        in   system clock
//   reset      in   synchronous active-high reset
//   row_n      in   [3:0] keypad rows, active-low, asynchronous to clk
//   col_n      out  [3:0] keypad column drive, exactly one bit low
//   key_code   out  [3:0] hex code of the last accepted key
//   key_valid  out  one-clk pulse when a new key is accepted
//   key_down   out  high while an accepted key is held
//   value      out  [7:0] {previous key, newest key}
//
// Parameters:
//   PRESCALE   clk cycles each column is driven (>= 2)
//   DEBOUNCE   consecutive identical full scans to accept press/release (>= 1)
// -----------------------------------------------------------------------------
module keypad_hex_scanner
    import keypad_pkg::*;
#(
    parameter int PRESCALE = 8000,
    parameter int DEBOUNCE = 4
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [3:0] row_n,
    output logic [3:0] col_n,
    output logic [3:0] key_code,
    output logic       key_valid,
    output logic       key_down,
    output logic [7:0] value
);

    localparam int            PW         = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
    localparam logic [PW-1:0] PRESC_LAST = PW'(PRESCALE - 1);

    logic [PW-1:0]   presc_reg;
    logic            tick;
    logic [1:0]      col_idx_reg;
    logic [3:0]      row_meta_reg;
    logic [3:0]      row_s_reg;
    logic [3:0][3:0] scan_rows;     // scan_rows[c] = row sample for column c
    logic [15:0]     low_mask;      // low_mask[r*4+c] = key (r,c) read low
    logic            scan_done;
    scan_class_t     scan_cls;

    // Two-flop synchronizer; idle (all rows high) after reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            row_meta_reg <= 4'hF;
            row_s_reg    <= 4'hF;
        end else begin
            row_meta_reg <= row_n;
            row_s_reg    <= row_meta_reg;
        end
    end

    // Column dwell timer: one tick every PRESCALE clocks.
    assign tick = (presc_reg == PRESC_LAST);

    always_ff @(posedge clk) begin
        if (reset) begin
            presc_reg <= '0;
        end else if (tick) begin
            presc_reg <= '0;
        end else begin
            presc_reg <= presc_reg + PW'(1);
        end
    end

    // The row sample for the current column is taken on the tick, i.e. at the
    // end of its dwell, so the pad and synchronizer have had time to settle.
    always_ff @(posedge clk) begin
        if (reset) begin
            col_idx_reg <= 2'd0;
        end else if (tick) begin
            col_idx_reg <= col_idx_reg + 2'd1;
        end
    end

    assign col_n = ~(4'b0001 << col_idx_reg);

    // Columns 0..2 are held in accumulators; column 3 is taken live from the
    // synchronizer on the completing tick so the result is classified and
    // presented to the FSM in that same cycle.
    generate
        for (genvar gi = 0; gi < 3; gi++) begin : g_col_acc
            logic [3:0] col_acc_reg;
            always_ff @(posedge clk) begin
                if (reset) begin
                    col_acc_reg <= 4'hF;
                end else if (tick && (col_idx_reg == 2'(gi))) begin
                    col_acc_reg <= row_s_reg;
                end
            end
            assign scan_rows[gi] = col_acc_reg;
        end
    endgenerate

    assign scan_rows[3] = row_s_reg;

    // Flatten to one bit per keypad position, row-major, active-high.
    generate
        for (genvar gi = 0; gi < 16; gi++) begin : g_low_mask
            assign low_mask[gi] = ~scan_rows[gi % 4][gi / 4];
        end
    endgenerate

    assign scan_done = tick && (col_idx_reg == 2'd3);
    assign scan_cls  = classify_scan(low_mask);

    keypad_debounce_fsm #(
        .DEBOUNCE (DEBOUNCE)
    ) u_debounce_fsm (
        .clk         (clk),
        .reset       (reset),
        .scan_done   (scan_done),
        .scan_result (scan_cls.result),
        .scan_code   (scan_cls.code),
        .key_code    (key_code),
        .key_valid   (key_valid),
        .key_down    (key_down),
        .value       (value)
    );

endmodule

// File: tb/tb_keypad_hex_scanner.sv
// -----------------------------------------------------------------------------
// tb_keypad_hex_scanner
//
// Drives a model keypad (a set of pressed hex keys wired onto rows/columns) and
// checks the scanner against a scan-level reference built from run lengths:
// a press is accepted when DEBOUNCE consecutive scans each show the same lone
// key while no key is down; a release when DEBOUNCE consecutive scans are empty.
// Key sets change only at scan boundaries, so every scan sees one stable set.
// -----------------------------------------------------------------------------
module tb_keypad_hex_scanner;

    localparam int P    = 4;
    localparam int DB   = 3;
    localparam int SCAN = 4 * P;

    // Keypad face, row 0 first, four hex codes per row, column 0 leftmost.
    localparam logic [63:0] LAYOUT_ROWS = 64'h123A_456B_789C_E0FD;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic [3:0] row_n;
    logic [3:0] col_n;
    logic [3:0] key_code;
    logic       key_valid;
    logic       key_down;
    logic [7:0] value;

    logic [15:0] pressed = 16'h0000;   // bit k set = hex key k held down

    int compared   = 0;
    int mismatched = 0;
    int valid_seen = 0;

    // Reference state
    logic       m_down;
    logic [3:0] m_code;
    logic [7:0] m_value;
    logic [3:0] run_key;
    int         run_len;
    int         none_len;
    int         m_pulses = 0;
    logic       m_pulse;

    keypad_hex_scanner #(
        .PRESCALE (P),
        .DEBOUNCE (DB)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .row_n     (row_n),
        .col_n     (col_n),
        .key_code  (key_code),
        .key_valid (key_valid),
        .key_down  (key_down),
        .value     (value)
    );

    always #5 clk = ~clk;

    // Passive matrix: a pressed key shorts its row to its column.
    always_comb begin
        row_n = 4'hF;
        for (int r = 0; r < 4; r++) begin
            for (int c = 0; c < 4; c++) begin
                if (!col_n[c] && pressed[LAYOUT_ROWS[63 - (r * 16 + c * 4) -: 4]]) begin
                    row_n[r] = 1'b0;
                end
            end
        end
    end

    always @(negedge clk) begin
        if (key_valid) valid_seen++;
    end

    function automatic logic [15:0] kbit(input int code);
        logic [15:0] one;
        one = 16'h0001;
        return one << code;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        compared++;
        assert (obs === exp) else begin
            mismatched++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_down   = 1'b0;
        m_code   = 4'h0;
        m_value  = 8'h00;
        run_key  = 4'h0;
        run_len  = 0;
        none_len = 0;
        m_pulse  = 1'b0;
    endtask

    task automatic model_scan(input logic [15:0] set);
        int         n;
        logic [3:0] k;
        n = $countones(set);
        k = 4'h0;
        for (int i = 0; i < 16; i++) if (set[i]) k = 4'(i);
        if (n == 1) begin
            if (run_len > 0 && run_key == k) run_len++;
            else begin
                run_key = k;
                run_len = 1;
            end
        end else begin
            run_len = 0;
        end
        if (n == 0) none_len++;
        else none_len = 0;
        m_pulse = 1'b0;
        if (!m_down && n == 1 && run_len == DB) begin
            m_down  = 1'b1;
            m_code  = k;
            m_value = {m_value[3:0], k};
            m_pulse = 1'b1;
        end else if (m_down && none_len == DB) begin
            m_down = 1'b0;
        end
    endtask

    // Called in the first cycle of a scan; returns #1 after the next scan's
    // completing edge, when key_valid for that scan is visible.
    task automatic do_scan(input logic [15:0] set);
        pressed = set;
        repeat (SCAN) @(posedge clk);
        #1;
        chk("pulse_count", valid_seen, m_pulses);
        model_scan(set);
        if (m_pulse) m_pulses++;
        chk("key_valid", key_valid, m_pulse);
        chk("key_code", key_code, m_code);
        chk("value", value, m_value);
        chk("key_down", key_down, m_down);
        chk("col_n_scan_start", col_n, 4'hE);
    endtask

    task automatic do_scans(input logic [15:0] set, input int n);
        for (int i = 0; i < n; i++) do_scan(set);
    endtask

    // Leaves the bench mid-way through cycle 0 of a fresh scan.
    task automatic do_reset();
        @(negedge clk);
        reset = 1'b1;
        @(posedge clk);
        #1;
        chk("rst_col_n", col_n, 4'hE);
        chk("rst_key_code", key_code, 4'h0);
        chk("rst_key_valid", key_valid, 1'b0);
        chk("rst_key_down", key_down, 1'b0);
        chk("rst_value", value, 8'h00);
        @(negedge clk);
        reset = 1'b0;
        model_reset();
    endtask

    initial begin
        int         sel;
        int         len;
        logic [3:0] last_key;
        logic [15:0] s;
        logic [3:0] exp_col;

        model_reset();
        last_key = 4'h5;
        repeat (3) @(posedge clk);
        do_reset();

        // Column sequencing with no key: each column held P clocks.
        for (int i = 0; i < SCAN; i++) begin
            exp_col = ~(4'b0001 << (i / P));
            chk("col_seq", col_n, exp_col);
            chk("col_seq_no_valid", key_valid, 1'b0);
            @(negedge clk);
        end
        model_scan(16'h0000);

        // '6' held, then released.
        do_scans(kbit(6), 4);
        chk("code_6", key_code, 4'h6);
        chk("value_06", value, 8'h06);
        chk("down_6", key_down, 1'b1);
        do_scans(16'h0000, 3);
        chk("released_6", key_down, 1'b0);

        // 'A' then '0' shift through value.
        do_scans(kbit(4'hA), 4);
        chk("value_6A", value, 8'h6A);
        do_scans(16'h0000, 3);
        do_scans(kbit(0), 4);
        chk("value_A0", value, 8'hA0);
        do_scans(16'h0000, 3);

        // Bouncing '5': 2 on, 1 off, 3 on.
        do_scans(kbit(5), 2);
        do_scans(16'h0000, 1);
        do_scans(kbit(5), 2);
        chk("bounce_not_yet", key_down, 1'b0);
        do_scans(kbit(5), 1);
        chk("bounce_code_5", key_code, 4'h5);
        do_scans(16'h0000, 3);

        // '1'+'2' from idle: nothing. Then '1' alone, then add '2' while held.
        do_scans(kbit(1) | kbit(2), 4);
        chk("multi_idle_down", key_down, 1'b0);
        do_scans(kbit(1), 3);
        do_scans(kbit(1) | kbit(2), 3);
        chk("multi_held_down", key_down, 1'b1);
        chk("multi_held_code", key_code, 4'h1);
        do_scans(16'h0000, 3);

        // Reset in PRESS_DB, key stays held and is re-accepted.
        do_scans(kbit(9), 1);
        repeat (7) @(posedge clk);
        do_reset();
        do_scans(kbit(9), 3);
        chk("reaccept_9", value, 8'h09);

        // Reset while HELD, key stays held and is re-accepted.
        do_scans(kbit(9), 2);
        repeat (5) @(posedge clk);
        do_reset();
        do_scans(kbit(9), 2);
        chk("held_reset_wait", key_down, 1'b0);
        do_scans(kbit(9), 1);
        chk("held_reaccept_down", key_down, 1'b1);
        do_scans(16'h0000, 3);

        // Random segments of stable key sets.
        for (int seg = 0; seg < 40; seg++) begin
            sel = int'($urandom_range(0, 99));
            len = int'($urandom_range(1, 5));
            if (sel < 35) begin
                s = 16'h0000;
            end else if (sel < 85) begin
                if ($urandom_range(0, 1) == 1) last_key = 4'($urandom_range(0, 15));
                s = kbit(int'(last_key));
            end else begin
                s = kbit(int'($urandom_range(0, 15))) | kbit(int'($urandom_range(0, 15)));
            end
            do_scans(s, len);
        end
        do_scans(16'h0000, 3);
        @(negedge clk);
        chk("final_pulse_count", valid_seen, m_pulses);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
